seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Output-side counterpart to the stopwatch's button-input path.
- Reads the four BCD digit values (min_1, min_0, sec_1, sec_0) and drives the board's 4-digit common-anode seven-segment display.
- Time-multiplexes the digits with an internal scan prescaler and decodes BCD to segments.
- Blanks the selected digit at a 2 Hz rate while the watch is in adjust mode.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit (100 MHz / 50000 = 2 kHz per digit, 500 Hz frame)
BLINK_DIV, 25000000, clk cycles per blink-phase half-period (0.25 s at 100 MHz, giving a 2 Hz blink)

Ports:
clk  input  1  board clock, 100 MHz
rst  input  1  synchronous reset, active-low (0 = reset)
min_1  input  4  BCD tens-of-minutes digit, leftmost
min_0  input  4  BCD minutes digit
sec_1  input  4  BCD tens-of-seconds digit
sec_0  input  4  BCD seconds digit, rightmost
blink_en  input  1  adjust mode active; enables blanking of the selected digit
blink_sel  input  2  digit to blink: 11=min_1, 10=min_0, 01=sec_1, 00=sec_0
an  output  4  anode enables, active-low; an[3]=min_1 … an[0]=sec_0
seg  output  7  cathodes, active-low, seg[6:0]=g,f,e,d,c,b,a
dp  output  1  decimal point, active-low; lit only while min_0 is scanned (min/sec separator)

Behaviour:
- All state updates on posedge clk. rst is sampled synchronously; rst=0 overrides everything.
- Reset values:
  - scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0
  - an=4'b1111, seg=7'b1111111, dp=1 (display dark)
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On terminal count it wraps to 0 and idx advances 0→1→2→3→0.
  - idx selects the digit: 0=sec_0, 1=sec_1, 2=min_0, 3=min_1.
  - Each digit is lit for exactly SCAN_DIV cycles.
- Outputs are registered. an/seg/dp reflect idx and the digit inputs sampled on the same edge:
  - 1-cycle latency from an idx change or an input change to the outputs.
  - First cycle after reset release: an=4'b1110 showing sec_0.
- an: exactly one bit low (bit idx), except when blanked (all ones).
- Decode, seg values as g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 display a dash: 0111111.
- dp=0 when idx=2 and the digit is not blanked; otherwise dp=1.
- Blink:
  - When blink_en=1, blink_cnt counts 0..BLINK_DIV-1; on terminal count it wraps and blink_phase toggles.
  - When blink_en=0, blink_cnt and blink_phase are held at 0, so entering adjust mode always starts with the digit visible for a full half-period.
  - Blank condition: blink_en=1, blink_sel==idx, and blink_phase=1. While blanked: an=4'b1111, seg=7'b1111111, dp=1. The scan continues unaffected.
- blink_sel changes mid-phase take effect on the next cycle; blink_cnt is not restarted.
- Scan and blink counters are independent; simultaneous terminal counts are both honoured in the same cycle.
- Reset mid-scan or mid-blink:
  - Display goes dark on the next edge.
  - idx restarts at 0 and the blink phase restarts visible.
- Counter widths are sized by $clog2 of the divider parameters. Both parameters must be ≥2.

Test Plan:
1. SCAN_DIV=4, digits min_1=1, min_0=2, sec_1=3, sec_0=4, rst low 3 cycles then high.
   - Required: an dark during reset.
   - Then an=1110 with seg=0011001 for 4 cycles, then 1101 with seg=0110000, 1011 with seg=0100100 and dp=0, 0111 with seg=1111001, then back to 1110.
2. Sweep sec_0 through 0–15 while idx=0.
   - Required: seg matches the decode list one cycle after each change; 10–15 give 0111111.
3. SCAN_DIV=4, BLINK_DIV=8, blink_en=1, blink_sel=01.
   - Required: digit sec_1 is lit for its slots during the first 8 cycles; for the next 8 cycles, an=1111 during idx=1 slots; the pattern repeats.
   - Other digits are never blanked.
4. Drop blink_en while blink_phase=1.
   - Required: the selected digit is visible on the next scan slot.
   - On re-assert, the first 8 cycles are visible.
5. Assert rst=0 mid-frame at idx=2 with blink_phase=1.
   - Required: next edge gives an=1111, seg=1111111, dp=1.
   - After release, scan restarts at an=1110 with blink visible.
6. Change blink_sel 00→11 mid-phase.
   - Required: blanking moves to min_1 the next cycle without restarting blink_cnt.

Source files
------------

// File: rtl/seg_display_scan.sv
// Four-digit common-anode seven-segment driver: time-multiplexed scan, BCD decode,
// and 2 Hz blanking of one selected digit while the watch is in adjust mode.
module seg_display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_1,
  input  logic [3:0] min_0,
  input  logic [3:0] sec_1,
  input  logic [3:0] sec_0,
  input  logic       blink_en,
  input  logic [1:0] blink_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic       blank;

  always_comb begin
    digit = sec_0;
    case (idx)
      2'd0: digit = sec_0;
      2'd1: digit = sec_1;
      2'd2: digit = min_0;
      2'd3: digit = min_1;
      default: digit = sec_0;
    endcase
  end

  // seg bit order is g..a, active-low
  always_comb begin
    seg_dec = 7'b0111111;
    case (digit)
      4'd0: seg_dec = 7'b1000000;
      4'd1: seg_dec = 7'b1111001;
      4'd2: seg_dec = 7'b0100100;
      4'd3: seg_dec = 7'b0110000;
      4'd4: seg_dec = 7'b0011001;
      4'd5: seg_dec = 7'b0010010;
      4'd6: seg_dec = 7'b0000010;
      4'd7: seg_dec = 7'b1111000;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
  end

  assign blank = blink_en && (blink_sel == idx) && blink_phase;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt    <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // holding the blink state at zero outside adjust mode makes every entry start visible
      if (!blink_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
      seg <= blank ? 7'b1111111 : seg_dec;
      dp  <= !((idx == 2'd2) && !blank);
    end
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with small dividers; expected outputs are derived
// per cycle from the edge count since reset release and the edge at which blinking began.
module tb_seg_display_scan;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] min_1 = 4'd1, min_0 = 4'd2, sec_1 = 4'd3, sec_0 = 4'd4;
  logic       blink_en = 1'b0;
  logic [1:0] blink_sel = 2'b00;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int n = 0;   // active edges since reset release
  int b = 1;   // edge at which the current blink run began counting

  always #5 clk = ~clk;

  seg_display_scan #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst),
    .min_1(min_1), .min_0(min_0), .sec_1(sec_1), .sec_0(sec_0),
    .blink_en(blink_en), .blink_sel(blink_sel),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got an/seg/dp=%b_%b_%b exp %b_%b_%b", tag, n,
               got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction

  // one clock: expectation from inputs present at the edge, compared #1 after it
  task automatic cyc(input string tag);
    logic [1:0]  i;
    logic        ph, blank;
    logic [3:0]  d;
    logic [11:0] e;
    if (!rst) begin
      e = {4'b1111, 7'b1111111, 1'b1};
    end else begin
      n++;
      i = 2'(((n - 1) / 4) % 4);
      ph = (((n - b) / 8) % 2) == 1;
      blank = blink_en && (blink_sel == i) && ph;
      case (i)
        2'd0: d = sec_0;
        2'd1: d = sec_1;
        2'd2: d = min_0;
        default: d = min_1;
      endcase
      e = {blank ? 4'b1111 : ~(4'b0001 << i), blank ? 7'b1111111 : dec(d),
           !((i == 2'd2) && !blank)};
    end
    @(posedge clk);
    #1;
    chk(tag, {an, seg, dp}, e);
  endtask

  initial begin
    // reset held 3 cycles, then one full frame plus wrap
    repeat (3) cyc("reset_dark");
    rst = 1'b1;
    repeat (17) cyc("scan");

    // sweep sec_0 through all codes, each applied just before an idx=0 edge
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 16; k++) begin
        if (((n / 4) % 4) == 0) break;
        cyc("sweep_wait");
      end
      sec_0 = 4'(v);
      cyc("sweep");
    end
    sec_0 = 4'd4;

    // blink sec_1, aligned so its scan slots fall inside the blanked half-period
    for (int k = 0; k < 16; k++) begin
      if ((n % 16) == 12) break;
      cyc("align_blink");
    end
    blink_sel = 2'b01;
    blink_en  = 1'b1;
    b = n + 1;
    repeat (48) cyc("blink");

    // drop adjust mode during the blanked phase, then re-enter
    for (int k = 0; k < 16; k++) begin
      if ((((n + 1 - b) / 8) % 2) == 1) break;
      cyc("wait_phase1");
    end
    blink_en = 1'b0;
    repeat (20) cyc("unblink");
    for (int k = 0; k < 16; k++) begin
      if ((n % 16) == 0) break;
      cyc("align_reblink");
    end
    blink_en = 1'b1;
    b = n + 1;
    repeat (16) cyc("reblink");

    // reset while min_0 is scanned in the blanked phase
    for (int k = 0; k < 32; k++) begin
      if (((n / 4) % 4) == 2 && (((n + 1 - b) / 8) % 2) == 1) break;
      cyc("align_rst");
    end
    rst = 1'b0;
    repeat (3) cyc("rst_mid");
    rst = 1'b1;
    n = 0;
    b = 1;
    blink_sel = 2'b00;
    repeat (12) cyc("post_rst");

    // blanking target moves to min_1 without restarting the blink count
    blink_sel = 2'b11;
    repeat (8) cyc("sel_move");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
